cla_serial_add_ctrl: RTL
========================

// Module: cla_serial_add_ctrl
// PURPOSE
//  Sequencer that performs WIDTH-bit additions on a single 4-bit carry-lookahead slice.
//  It feeds one nibble per cycle, LSB first, and chains the slice carry through a register.
//  It trades latency for area and sits between a requester (start/ready handshake) and the 4-bit CLA datapath.
// PARAMETERS
//  WIDTH    16  operand/result width in bits; must be a multiple of 4 and >= 8
//  NIBBLES  WIDTH/4  derived localparam; number of slice passes per operation
// PORTS
//  clk      in   1      system clock; all state updates on the rising edge
//  rst_n    in   1      reset, asynchronous and active-low
//  start    in   1      request; accepted only when ready=1
//  ready    out  1      1 in IDLE and DONE; 0 in RUN
//  a        in   WIDTH  operand A; sampled on accepted start
//  b        in   WIDTH  operand B; sampled on accepted start
//  cin      in   1      carry-in; sampled on accepted start
//  sub      in   1      subtract request; only present with CLA_SUB_EN
//  busy     out  1      1 while in RUN
//  done     out  1      1-cycle pulse; sum/cout are valid in the same cycle
//  sum      out  WIDTH  result; held stable from done until the next accepted start
//  cout     out  1      final carry-out; held with sum
// BEHAVIOUR
//  Reset: state=IDLE. ready=1, busy=0, done=0, sum=0, cout=0, cnt=0, carry register=0.
//  FSM IDLE -> RUN on start&ready:
//   - latch a into opa_q and b into opb_q
//   - load the carry register from cin
//   - cnt<=0
//  RUN, every cycle:
//   - slice inputs: opa_q[3:0], opb_q[3:0], carry register
//   - opa_q and opb_q shift right by 4
//   - slice sum is shifted into sum_q from the top (sum_q <= {slice_s, sum_q[WIDTH-1:4]})
//   - carry register <= slice cout
//   - cnt++
//  RUN -> DONE when cnt==NIBBLES-1, i.e. after the last nibble is processed.
//  DONE lasts exactly one cycle with done=1 and ready=1.
//   - start in DONE is accepted: DONE -> RUN directly (back-to-back operation, no IDLE bubble)
//   - otherwise DONE -> IDLE
//  Latency: done is asserted NIBBLES+1 cycles after the start edge (5 cycles for WIDTH=16).
//   Throughput: one operation per NIBBLES+1 cycles.
//  sum/cout update only when DONE is entered. The internal sum_q is not visible while busy;
//   the previous result is held.
//  start with ready=0 (RUN) is ignored; no queuing, no error.
//  Arithmetic is modulo 2^WIDTH. cout = bit WIDTH of a+b+cin.
//  rst_n low mid-operation: the operation is aborted immediately and all outputs take their reset values.
//   After release there is no done for the aborted operation.
//  X on a/b/cin when start is not accepted has no effect.
// CONFIGURATION
//  CLA_SUB_EN defined:
//   - sub port exists
//   - on accepted start with sub=1: opb_q <= ~b, carry register <= 1 (cin ignored), giving sum=a-b
//   - cout=1 means no borrow
//  CLA_SUB_EN undefined: no sub port; addition only.
// STRUCTURE
//  Shared package cla_pkg:
//   - SLICE_W=4
//   - FSM state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2
//   - cnt width function clog2(NIBBLES)
//  One sub-module: cla4_slice, the 4-bit carry-lookahead adder (a,b,cin -> s,cout, purely combinational).
//   It is instantiated once here; the controller contains no adder logic of its own.
// TESTING
//  WIDTH=16 throughout.
//  1. a=16'hFFFF, b=16'h0001, cin=0, start -> done at cycle 5, sum=16'h0000, cout=1.
//  2. a=16'h1234, b=16'h4321, cin=1 -> sum=16'h5556, cout=0. ready=0 during cycles 1-4.
//  3. start pulsed again at cycle 2 with a=16'hAAAA -> ignored; result still 16'h5556; exactly one done pulse.
//  4. start held high across DONE with a=16'h0F0F, b=16'h00F1, cin=0
//     -> second done 5 cycles after the first, sum=16'h1000, cout=0.
//  5. rst_n low at cycle 3 of an operation -> outputs immediately 0, ready=1;
//     no done after release; the next operation completes normally.
//  6. (CLA_SUB_EN) a=16'h0005, b=16'h0007, sub=1 -> sum=16'hFFFE, cout=0;
//     a=16'h0007, b=16'h0005, sub=1 -> sum=16'h0002, cout=1.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared definitions for the serial carry-lookahead adder controller and its 4-bit slice.
package cla_pkg;
  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Minimum of one bit so a two-pass configuration still has a usable counter.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) r = i + 1;
      else r = r;
    end
    return r;
  endfunction
endpackage

// File: rtl/cla4_slice.sv
// Purely combinational 4-bit carry-lookahead adder slice.
module cla4_slice
  import cla_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);
  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic               c1, c2, c3;

  assign g = a & b;
  assign p = a ^ b;

  assign c1   = g[0] | (p[0] & cin);
  assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s = p ^ {c3, c2, c1, cin};
endmodule

// File: rtl/cla_serial_add_ctrl.sv
// Nibble-serial WIDTH-bit adder built around one cla4_slice, LSB nibble first.
// Optional feature: define CLA_SUB_EN to add the sub port (a - b via ~b and carry-in 1).
module cla_serial_add_ctrl
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int NIBBLES = WIDTH / SLICE_W;
  localparam int CNT_W   = clog2(NIBBLES);

  state_t                   state, next_state;
  logic [WIDTH-1:0]         opa_q, opb_q;
  logic [WIDTH-SLICE_W-1:0] sum_q;
  logic [CNT_W-1:0]         cnt;
  logic                     carry_q;
  logic [SLICE_W-1:0]       slice_s;
  logic                     slice_cout;
  logic [WIDTH-1:0]         sum_next;
  logic                     accept, last, sub_eff;

`ifdef CLA_SUB_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  cla4_slice u_slice (
    .a    (opa_q[SLICE_W-1:0]),
    .b    (opb_q[SLICE_W-1:0]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // sum_q only keeps the upper nibbles; the full result exists once the last slice sum arrives.
  assign sum_next = {slice_s, sum_q};
  assign accept   = start & ready;
  assign last     = (state == RUN) && (cnt == CNT_W'(NIBBLES - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;  else next_state = IDLE;
      RUN:     if (last)  next_state = DONE; else next_state = RUN;
      DONE:    if (start) next_state = RUN;  else next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      IDLE:    ready = 1'b1;
      RUN:     busy  = 1'b1;
      DONE:    begin ready = 1'b1; done = 1'b1; end
      default: ready = 1'b0;
    endcase
  end

  // Operand shifting, carry chaining and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q   <= {WIDTH{1'b0}};
      opb_q   <= {WIDTH{1'b0}};
      sum_q   <= {(WIDTH-SLICE_W){1'b0}};
      cnt     <= {CNT_W{1'b0}};
      carry_q <= 1'b0;
      sum     <= {WIDTH{1'b0}};
      cout    <= 1'b0;
    end else if (accept) begin
      opa_q   <= a;
      opb_q   <= sub_eff ? ~b : b;
      carry_q <= sub_eff ? 1'b1 : cin;
      cnt     <= {CNT_W{1'b0}};
    end else if (state == RUN) begin
      opa_q   <= {{SLICE_W{1'b0}}, opa_q[WIDTH-1:SLICE_W]};
      opb_q   <= {{SLICE_W{1'b0}}, opb_q[WIDTH-1:SLICE_W]};
      sum_q   <= sum_next[WIDTH-1:SLICE_W];
      carry_q <= slice_cout;
      cnt     <= cnt + CNT_W'(1);
      if (last) begin
        sum  <= sum_next;
        cout <= slice_cout;
      end
    end
  end
endmodule
